dim_sum_accumulator: RTL and testbench
======================================

Name: dim_sum_accumulator

Overview:
- Streaming stage directly upstream of the mean-reduction block.
- Accepts signed elements of one reduction row, one per handshake beat, and accumulates exactly DIM_SIZE of them at full precision.
- Emits one {sum, element count} result per row over a valid/ready handshake; the downstream mean stage divides the sum by the count.
- Flags rows whose length disagrees with DIM_SIZE.

Parameters:
DATA_W, 32, width of signed input element.
DIM_SIZE, 16, elements per reduction row (>=2).
CNT_W, $clog2(DIM_SIZE+1), width of element counter and out_count.
ACC_W, DATA_W+$clog2(DIM_SIZE), accumulator and out_sum width; overflow-free.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  input element valid.
in_ready  output  1  block accepts element this cycle.
in_data  input  DATA_W  signed element (two's complement).
in_last  input  1  producer marks final element of row.
out_valid  output  1  result register holds a result.
out_ready  input  1  downstream accepts result.
out_sum  output  ACC_W  signed row sum.
out_count  output  CNT_W  elements summed in this row.
err_len  output  1  sticky row-length error.
rows_done  output  16  rows emitted, wraps 0xFFFF->0.

Behaviour:
- Reset: asynchronous; clears immediately, independent of clk. Values held at reset: accumulator=0, cnt=0, out_valid=0, out_sum=0, out_count=0, err_len=0, rows_done=0. A partial row in flight is discarded; no result is emitted for it.
- Beat accepted when in_valid && in_ready.
- in_data is sign-extended to ACC_W before addition.
- close = accepted && (in_last || cnt==DIM_SIZE-1).
- Accepted non-closing beat: acc <= acc + in_data; cnt <= cnt+1.
- Closing beat, same edge:
  - out_sum <= acc + in_data; out_count <= cnt+1; out_valid <= 1.
  - acc <= 0; cnt <= 0.
  - rows_done increments when this result is accepted downstream, not at close.
- in_ready = (cnt != DIM_SIZE-1 && !in_last) || !out_valid || out_ready.
  - Non-closing beats always accepted, even while a result is pending (accumulator is separate from the result register).
  - A closing beat stalls until the result register is free or draining this cycle.
  - in_ready depends combinationally on out_ready and in_last. Producers must not make in_valid depend on in_ready.
- Output handshake:
  - out_valid && out_ready clears out_valid, unless a closing beat is accepted on the same edge; then the new result loads and out_valid stays 1.
  - out_sum and out_count stable while out_valid && !out_ready.
- Latency: 1 cycle from closing-beat acceptance to out_valid.
- Throughput: 1 element/cycle sustained when out_ready=1.
- Length checking:
  - in_last on beat index k < DIM_SIZE-1: row closes early, out_count=k+1, err_len <= 1.
  - in_last=0 on beat DIM_SIZE-1: row closes at DIM_SIZE, err_len <= 1.
  - err_len is cleared only by rst.
- Arithmetic: ACC_W bits; DIM_SIZE full-scale elements cannot overflow. No saturation or rounding.
- in_data/in_last ignored when not accepted.

Test Plan:
- DIM_SIZE=4, out_ready=1, inputs 1,2,3,4 with in_last on 4th -> one cycle after 4th beat: out_valid=1, out_sum=10, out_count=4, err_len=0, rows_done=1 next cycle.
- Inputs -5,-5,-5,-5 -> out_sum = -20 sign-extended to ACC_W (0x3FFFFFFEC for ACC_W=34); 0x7FFFFFFF x4 -> out_sum=0x1FFFFFFFC; 0x80000000 x4 -> out_sum=0x200000000.
- Backpressure, out_ready=0 after row A (sum 10) completes:
  - Row B beats 5,6,7 accepted.
  - in_ready=0 on B's 4th beat (8) until out_ready=1.
  - On the release edge: A consumed, B loads (out_sum=26), out_valid stays 1.
  - out_sum holds 10 throughout the stall.
- Early last, inputs 7,8 with in_last on 8 -> out_sum=15, out_count=2, err_len=1. Next row 1,1,1,1 -> out_sum=4, out_count=4, err_len remains 1.
- Missing last on 4th beat -> row closes, out_count=4, err_len=1. Row boundaries stay aligned to DIM_SIZE.
- Reset mid-row after 2 beats (9,9) with out_valid=1 pending:
  - Asserting rst clears out_valid immediately, without a clock edge.
  - After release, row 1,2,3,4 -> out_sum=10; no residue of 18.

Source files
------------

// File: rtl/dim_sum_accumulator.sv
// Row-sum stage feeding the mean-reduction block.
// Accumulates DIM_SIZE signed elements per row at full precision and emits
// {sum, count} over a valid/ready handshake. Rows closed early by in_last, or
// missing in_last on their final element, raise the sticky err_len flag.
module dim_sum_accumulator #(
    parameter int DATA_W   = 32,
    parameter int DIM_SIZE = 16,
    parameter int CNT_W    = $clog2(DIM_SIZE + 1),
    parameter int ACC_W    = DATA_W + $clog2(DIM_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              err_len,
    output logic [15:0]       rows_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM_SIZE - 1);

    logic [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] out_sum_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_valid_reg;
    logic             err_len_reg;
    logic [15:0]      rows_done_reg;

    logic [ACC_W-1:0] in_ext;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             at_last_idx;
    logic             accept;
    logic             close;
    logic             len_bad;
    logic             out_fire;

    // Sign-extend the element to accumulator width, one bit per generate step.
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_sext
            if (gi < DATA_W) begin : g_data
                assign in_ext[gi] = in_data[gi];
            end else begin : g_sign
                assign in_ext[gi] = in_data[DATA_W-1];
            end
        end
    endgenerate

    assign at_last_idx = (cnt_reg == LAST_IDX);
    assign acc_next    = acc_reg + in_ext;
    assign cnt_next    = cnt_reg + CNT_W'(1);
    assign out_fire    = out_valid_reg && out_ready;

    // Non-closing beats never wait; a closing beat needs the result register
    // to be empty or draining on this same edge.
    assign in_ready = (!at_last_idx && !in_last) || !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || at_last_idx);
    // Length error: in_last early, or absent on the final element.
    assign len_bad  = in_last ^ at_last_idx;

    // Running row accumulator and element index; cleared when a row closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (close) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end

    // Result register: loads on close (even while draining), else clears on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else if (close) begin
            out_sum_reg   <= acc_next;
            out_count_reg <= cnt_next;
            out_valid_reg <= 1'b1;
        end else if (out_fire) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Sticky row-length error, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len_reg <= 1'b0;
        end else if (close && len_bad) begin
            err_len_reg <= 1'b1;
        end
    end

    // Count results actually taken downstream; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_done_reg <= '0;
        end else if (out_fire) begin
            rows_done_reg <= rows_done_reg + 16'd1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign err_len   = err_len_reg;
    assign rows_done = rows_done_reg;

endmodule

// File: tb/tb_dim_sum_accumulator.sv
// Directed bench for dim_sum_accumulator with DIM_SIZE=4, DATA_W=32.
// Expected row results are queued when the closing beat is accepted and
// compared when the result is handed off downstream.
module tb_dim_sum_accumulator;

    localparam int DATA_W   = 32;
    localparam int DIM_SIZE = 4;
    localparam int CNT_W    = $clog2(DIM_SIZE + 1);
    localparam int ACC_W    = DATA_W + $clog2(DIM_SIZE);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              err_len;
    logic [15:0]       rows_done;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             err;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_rows = 0;

    longint exp_acc = 0;
    int     exp_cnt = 0;
    logic   exp_err = 1'b0;

    dim_sum_accumulator #(
        .DATA_W  (DATA_W),
        .DIM_SIZE(DIM_SIZE),
        .CNT_W   (CNT_W),
        .ACC_W   (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .err_len  (err_len),
        .rows_done(rows_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference row model: update on an accepted beat, queue result on close.
    task automatic model_beat(input logic [DATA_W-1:0] d, input logic l);
        res_t   r;
        logic   closing;
        closing = l || (exp_cnt == DIM_SIZE - 1);
        if (closing && (l != (exp_cnt == DIM_SIZE - 1)))
            exp_err = 1'b1;
        exp_acc = exp_acc + longint'($signed(d));
        exp_cnt = exp_cnt + 1;
        if (closing) begin
            r.sum = exp_acc[ACC_W-1:0];
            r.cnt = CNT_W'(exp_cnt);
            r.err = exp_err;
            exp_q.push_back(r);
            exp_acc = 0;
            exp_cnt = 0;
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        logic rdy;
        int   n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("in_ready_timeout", 64'(rdy), 64'd1);
        else      model_beat(d, l);
        $display("beat data=%0h last=%0b accepted=%0b", d, l, rdy);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Downstream monitor: compare each handed-off result against the queue.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
            exp_rows = 0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sum", 64'(out_sum), 64'(e.sum));
                chk("sb_count", 64'(out_count), 64'(e.cnt));
                chk("sb_err_len", 64'(err_len), 64'(e.err));
                chk("sb_rows_done", 64'(rows_done), 64'(exp_rows[15:0]));
                $display("result sum=%0h count=%0d err=%0b rows_done=%0d", out_sum, out_count, err_len, rows_done);
                exp_rows++;
            end
        end
    end

    initial begin
        int n;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_rows_done", 64'(rows_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic row: 1-cycle latency, sum 10, rows_done counts on handoff.
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        idle();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_sum", 64'(out_sum), 64'd10);
        chk("t1_out_count", 64'(out_count), 64'd4);
        chk("t1_err_len", 64'(err_len), 64'd0);
        @(posedge clk); #1;
        chk("t1_rows_done", 64'(rows_done), 64'd1);

        // Sign extension and full-scale rows, back to back.
        send(-5, 0); send(-5, 0); send(-5, 0); send(-5, 1);
        chk("neg_sum", 64'(out_sum), 64'h3_FFFF_FFEC);
        send(32'h7FFF_FFFF, 0); send(32'h7FFF_FFFF, 0); send(32'h7FFF_FFFF, 0); send(32'h7FFF_FFFF, 1);
        chk("maxpos_sum", 64'(out_sum), 64'h1_FFFF_FFFC);
        send(32'h8000_0000, 0); send(32'h8000_0000, 0); send(32'h8000_0000, 0); send(32'h8000_0000, 1);
        chk("maxneg_sum", 64'(out_sum), 64'h2_0000_0000);
        idle();
        @(posedge clk); #1;

        // Backpressure: row A pending, row B's closing beat stalls.
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        out_ready = 1'b0;
        send(5, 0); send(6, 0); send(7, 0);
        in_valid = 1'b1; in_data = 8; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_sum_hold", 64'(out_sum), 64'd10);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_release", 64'(in_ready), 64'd1);
        model_beat(8, 1);
        @(posedge clk); #1;
        idle();
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_sum", 64'(out_sum), 64'd26);
        @(posedge clk); #1;

        // Early last, then a good row; err_len stays sticky.
        send(7, 0); send(8, 1);
        chk("early_sum", 64'(out_sum), 64'd15);
        chk("early_count", 64'(out_count), 64'd2);
        chk("early_err", 64'(err_len), 64'd1);
        send(1, 0); send(1, 0); send(1, 0); send(1, 1);
        chk("after_err_sum", 64'(out_sum), 64'd4);
        chk("after_err_sticky", 64'(err_len), 64'd1);

        // Missing last: row still closes at DIM_SIZE; next row stays aligned.
        send(2, 0); send(2, 0); send(2, 0); send(2, 0);
        chk("miss_count", 64'(out_count), 64'd4);
        chk("miss_sum", 64'(out_sum), 64'd8);
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        chk("align_sum", 64'(out_sum), 64'd10);
        idle();
        @(posedge clk); #1;

        // Asynchronous reset with a pending result and a partial row in flight.
        out_ready = 1'b0;
        send(5, 0); send(5, 0); send(5, 0); send(5, 1);
        send(9, 0); send(9, 0);
        idle();
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_sum", 64'(out_sum), 64'd0);
        exp_acc = 0; exp_cnt = 0; exp_err = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_err", 64'(err_len), 64'd0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 1);
        idle();
        chk("post_rst_sum", 64'(out_sum), 64'd10);
        chk("post_rst_count", 64'(out_count), 64'd4);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        chk("final_rows_done", 64'(rows_done), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
